dip_config_ctrl: RTL and testbench
==================================

# dip_config_ctrl

Controller that sequences the board's configuration DIP switches and shares the resulting configuration byte between the hardware scanner and the Zorro III host. After reset it serially scans an 8-bit parallel-in/serial-out shift register (74HC165-style) holding the DIP switches and publishes the value as `cfg`. It also serves host accesses to the config/status window already decoded at 0x8C0000 in the Z3 BAR. Host writes can override the switch value or request a rescan. Host accesses to the config register are stalled while a scan is in flight.

## Interface
- `CLK_DIV`, default 4: half-period of `DIP_SCK` and width of the load pulse, in CLK cycles; legal range 1..255.

- `CLK` in 1: system clock.
- `RESET_n` in 1: asynchronous, active-low reset.
- `sel` in 1: register window select, already qualified with slave_cycle && configured.
- `reg_sel` in 1: 0 = config register, 1 = control/status register (ADDR[2]).
- `FCS_n` in 1: Zorro full-cycle strobe, active low.
- `READ` in 1: 1 = host read, 0 = host write.
- `DIN` in 8: host write data (D31:24).
- `DOUT` out 8: host read data.
- `dtack` out 1: access acknowledge to the bus FSM.
- `DIP_LOAD_n` out 1: parallel-load strobe to the shift register.
- `DIP_SCK` out 1: shift clock to the shift register.
- `DIP_SDI` in 1: serial data (QH) from the shift register.
- `cfg` out 8: effective configuration.
- `cfg_valid` out 1: high once the first scan has completed.
- `ext_term` out 1: equals `cfg[0]`.

## Operation
- Internal state:
  - `dip_raw[7:0]`: last scan result.
  - `shadow[7:0]`: host override value.
  - `override`: 1 while the host override is in effect.
  - `cfg` = `override ? shadow : dip_raw`.
- Scanner FSM states: S_START, S_LOAD, S_SHLO, S_SHHI, S_DONE, S_IDLE. The scanner is busy in every state except S_IDLE.
  - S_START: lasts 1 cycle, then goes to S_LOAD.
  - S_LOAD: `DIP_LOAD_n`=0 for CLK_DIV cycles, then goes to S_SHLO with bit counter = 7.
  - S_SHLO: `DIP_SCK`=0 for CLK_DIV cycles. On the last cycle, `DIP_SDI` is sampled into position `bitcnt`, inverted (closed switch pulls low, which reads as 1). Then goes to S_SHHI.
  - S_SHHI: `DIP_SCK`=1 for CLK_DIV cycles. Then goes to S_SHLO with `bitcnt`-1; if `bitcnt` was 0, goes to S_DONE instead.
  - S_DONE: `dip_raw` is updated from the assembled byte and `cfg_valid` is set to 1; then goes to S_IDLE. Bit order is MSB first (bit 7 first).
- Host FSM states: H_IDLE, H_WAIT, H_ACK.
  - In H_IDLE, `sel && !FCS_n` triggers an access.
  - An access to the config register while the scanner is busy goes to H_WAIT; all other accesses go to H_ACK.
  - H_WAIT goes to H_ACK on the cycle the scanner is in S_IDLE.
  - On entry to H_ACK, `dtack` goes to 1 and the access is performed:
    - Read config: `DOUT` ← `cfg`.
    - Write config: `shadow` ← `DIN`, `override` ← 1.
    - Read control: `DOUT` ← {busy, override, cfg_valid, 5'b0}.
    - Write control, bit0=1: start a rescan (scanner goes to S_START) if the scanner is idle; ignored if it is busy.
    - Write control, bit1=1: `override` ← 0.
    - Both bits may be set in the same write.
  - H_ACK holds `dtack`=1 until `FCS_n`=1, then `dtack` ← 0 and the FSM returns to H_IDLE.
- A scan completing while `override`=1 updates `dip_raw` only; `cfg` is unchanged.

## Timing
- Reset values:
  - `DOUT`=8'hFF, `dtack`=0, `DIP_LOAD_n`=1, `DIP_SCK`=0.
  - `cfg`=8'h00, `cfg_valid`=0, `ext_term`=0.
  - `dip_raw`, `shadow` and `override` are all 0.
  - Scanner is in S_START; host FSM is in H_IDLE.
- Reset mid-scan or mid-access aborts immediately; the scan restarts automatically after reset release.
- All outputs are registered.
- Scan length from leaving S_START to `cfg_valid` rising is CLK_DIV×17 + 1 cycles; with CLK_DIV=4 this is 69 cycles.
- Unstalled access: `sel && !FCS_n` sampled at edge N gives `dtack`=1 and valid `DOUT` after edge N+1.
- Stalled config access: `dtack` rises one cycle after the scanner enters S_IDLE.
- `dtack` falls on the edge after `FCS_n` is sampled high, and is never re-asserted within the same strobe.
- A control-register rescan write produces `DIP_LOAD_n` falling 2 cycles after the `dtack` edge.
- A new access requires `FCS_n` to return high first.

## Test plan
- Reset release with DIP lines presenting 8'b1010_0110 (raw) → `cfg_valid` rises after 69 cycles (CLK_DIV=4); `cfg`=8'h59; `ext_term`=1.
- Config read issued 10 cycles after reset → held in H_WAIT; `dtack` rises 1 cycle after scan done; `DOUT`=8'h59; `dtack` drops after `FCS_n` goes high.
- Config write 8'h3C, change the switches, write control 8'h01 → `cfg` stays 8'h3C; status read returns 8'hE0 during the scan and 8'h60 afterwards.
- Write control 8'h02 → `override`=0 and `cfg` equals the new `dip_raw`.
- Rescan write while busy → no restart; scan length stays 69 cycles.
- Assert `RESET_n` mid-shift → `DIP_SCK`=0, `DIP_LOAD_n`=1, `cfg`=8'h00 immediately; a full rescan follows release.

Source files
------------

// File: rtl/dip_config_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dip_config_ctrl
// Brief   : Scans the config DIP switches through a 74HC165 chain and shares
//           the resulting byte with Zorro III host reads/writes.
// Revision: 1.0  initial release
// ============================================================================
module dip_config_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       sel,
  input  logic       reg_sel,
  input  logic       FCS_n,
  input  logic       READ,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       dtack,
  output logic       DIP_LOAD_n,
  output logic       DIP_SCK,
  input  logic       DIP_SDI,
  output logic [7:0] cfg,
  output logic       cfg_valid,
  output logic       ext_term
);

  localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_LOAD  = 3'd1,
    S_SHLO  = 3'd2,
    S_SHHI  = 3'd3,
    S_DONE  = 3'd4,
    S_IDLE  = 3'd5
  } scan_state_t;

  typedef enum logic [1:0] {
    H_IDLE = 2'd0,
    H_WAIT = 2'd1,
    H_ACK  = 2'd2
  } host_state_t;

  scan_state_t r_scan, w_scan_nxt;
  host_state_t r_host, w_host_nxt;

  logic [7:0] r_div;
  logic [2:0] r_bitcnt;
  logic [7:0] r_shift;
  logic [7:0] r_dip_raw;
  logic [7:0] r_shadow;
  logic       r_override;
  logic       r_rescan;

  logic       r_sel, r_reg_sel, r_fcs_n, r_read;
  logic [7:0] r_din;

  logic [7:0] r_dout, r_cfg;
  logic       r_dtack, r_load_n, r_sck, r_cfg_valid, r_ext_term;

  logic       w_div_last, w_busy, w_ack_entry, w_cfg_wr, w_ctl_wr, w_rescan_set;
  logic       w_ov_nxt;
  logic [7:0] w_raw_nxt, w_shadow_nxt, w_cfg_nxt;

  assign w_div_last   = (r_div == c_div_last);
  assign w_busy       = (r_scan != S_IDLE);
  assign w_ack_entry  = (w_host_nxt == H_ACK) && (r_host != H_ACK);
  assign w_cfg_wr     = w_ack_entry && !r_reg_sel && !r_read;
  assign w_ctl_wr     = w_ack_entry && r_reg_sel && !r_read;
  assign w_rescan_set = w_ctl_wr && r_din[0] && !w_busy && !r_rescan;

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_scan <= S_START;
      r_host <= H_IDLE;
    end else begin
      r_scan <= w_scan_nxt;
      r_host <= w_host_nxt;
    end
  end

  always_comb begin
    w_scan_nxt = r_scan;
    case (r_scan)
      S_START: w_scan_nxt = S_LOAD;
      S_LOAD:  if (w_div_last) w_scan_nxt = S_SHLO;
      S_SHLO:  if (w_div_last) w_scan_nxt = S_SHHI;
      S_SHHI:  if (w_div_last) w_scan_nxt = (r_bitcnt == 3'd0) ? S_DONE : S_SHLO;
      S_DONE:  w_scan_nxt = S_IDLE;
      S_IDLE:  if (r_rescan) w_scan_nxt = S_START;
      default: w_scan_nxt = S_START;
    endcase
  end

  // Config-register accesses must not observe a half-finished scan.
  always_comb begin
    w_host_nxt = r_host;
    case (r_host)
      H_IDLE:  if (r_sel && !r_fcs_n) w_host_nxt = (!r_reg_sel && w_busy) ? H_WAIT : H_ACK;
      H_WAIT:  if (!w_busy) w_host_nxt = H_ACK;
      H_ACK:   if (r_fcs_n) w_host_nxt = H_IDLE;
      default: w_host_nxt = H_IDLE;
    endcase
  end

  always_comb begin
    w_raw_nxt    = (r_scan == S_DONE) ? r_shift : r_dip_raw;
    w_shadow_nxt = w_cfg_wr ? r_din : r_shadow;
    w_ov_nxt     = r_override;
    if (w_cfg_wr)
      w_ov_nxt = 1'b1;
    else if (w_ctl_wr && r_din[1])
      w_ov_nxt = 1'b0;
    w_cfg_nxt = w_ov_nxt ? w_shadow_nxt : w_raw_nxt;
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_div    <= 8'd0;
      r_bitcnt <= 3'd7;
      r_shift  <= 8'd0;
      r_rescan <= 1'b0;
    end else begin
      if (w_scan_nxt != r_scan)
        r_div <= 8'd0;
      else if (w_busy)
        r_div <= r_div + 8'd1;
      if (r_scan == S_LOAD && w_div_last)
        r_bitcnt <= 3'd7;
      else if (r_scan == S_SHHI && w_div_last)
        r_bitcnt <= r_bitcnt - 3'd1;
      // Closed switch pulls the line low, which reads as a 1.
      if (r_scan == S_SHLO && w_div_last)
        r_shift[r_bitcnt] <= ~DIP_SDI;
      if (r_scan == S_IDLE && r_rescan)
        r_rescan <= 1'b0;
      else if (w_rescan_set)
        r_rescan <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      r_sel       <= 1'b0;
      r_reg_sel   <= 1'b0;
      r_fcs_n     <= 1'b1;
      r_read      <= 1'b1;
      r_din       <= 8'd0;
      r_dip_raw   <= 8'd0;
      r_shadow    <= 8'd0;
      r_override  <= 1'b0;
      r_dout      <= 8'hFF;
      r_dtack     <= 1'b0;
      r_load_n    <= 1'b1;
      r_sck       <= 1'b0;
      r_cfg       <= 8'd0;
      r_cfg_valid <= 1'b0;
      r_ext_term  <= 1'b0;
    end else begin
      r_sel      <= sel;
      r_reg_sel  <= reg_sel;
      r_fcs_n    <= FCS_n;
      r_read     <= READ;
      r_din      <= DIN;
      r_dip_raw  <= w_raw_nxt;
      r_shadow   <= w_shadow_nxt;
      r_override <= w_ov_nxt;
      r_dtack    <= (w_host_nxt == H_ACK);
      if (w_ack_entry && r_read)
        r_dout <= r_reg_sel ? {w_busy, r_override, r_cfg_valid, 5'b0} : r_cfg;
      r_load_n   <= (w_scan_nxt != S_LOAD);
      r_sck      <= (w_scan_nxt == S_SHHI);
      if (r_scan == S_DONE)
        r_cfg_valid <= 1'b1;
      r_cfg      <= w_cfg_nxt;
      r_ext_term <= w_cfg_nxt[0];
    end
  end

  assign DOUT       = r_dout;
  assign dtack      = r_dtack;
  assign DIP_LOAD_n = r_load_n;
  assign DIP_SCK    = r_sck;
  assign cfg        = r_cfg;
  assign cfg_valid  = r_cfg_valid;
  assign ext_term   = r_ext_term;

endmodule
`default_nettype wire

// File: tb/tb_dip_config_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dip_config_ctrl
// Brief   : Randomized host traffic and DIP patterns against a behavioural model.
// Revision: 1.0  initial release
// ============================================================================
module tb_dip_config_ctrl;

  localparam int c_clk_div  = 4;
  localparam int c_scan_len = 17 * c_clk_div + 1;

  logic       CLK = 1'b0;
  logic       RESET_n = 1'b1;
  logic       sel = 1'b0;
  logic       reg_sel = 1'b0;
  logic       FCS_n = 1'b1;
  logic       READ = 1'b1;
  logic [7:0] DIN = 8'd0;
  logic [7:0] DOUT;
  logic       dtack;
  logic       DIP_LOAD_n;
  logic       DIP_SCK;
  logic       DIP_SDI;
  logic [7:0] cfg;
  logic       cfg_valid;
  logic       ext_term;

  dip_config_ctrl #(.CLK_DIV(c_clk_div)) u_dut (
    .CLK(CLK), .RESET_n(RESET_n), .sel(sel), .reg_sel(reg_sel), .FCS_n(FCS_n),
    .READ(READ), .DIN(DIN), .DOUT(DOUT), .dtack(dtack), .DIP_LOAD_n(DIP_LOAD_n),
    .DIP_SCK(DIP_SCK), .DIP_SDI(DIP_SDI), .cfg(cfg), .cfg_valid(cfg_valid),
    .ext_term(ext_term)
  );

  always #5 CLK = ~CLK;

  // 74HC165 behaviour: parallel load on low strobe, shift toward QH on SCK rise.
  logic [7:0] sw_lines;
  logic [7:0] sr;
  always @(negedge DIP_LOAD_n) sr <= sw_lines;
  always @(posedge DIP_SCK) if (DIP_LOAD_n) sr <= {sr[6:0], 1'b1};
  assign DIP_SDI = sr[7];

  int   ncnt = 0, t_load = 0, n_loads = 0, load_cnt = 0, load_w = 0;
  int   n_sck = 0, sck_base = 0, t_valid = -1;
  logic p_load = 1'b1, p_sck = 1'b0, p_valid = 1'b0;

  always @(posedge CLK) begin
    #1;
    ncnt++;
    if (p_load && !DIP_LOAD_n) begin
      t_load = ncnt; n_loads++; sck_base = n_sck; load_cnt = 0;
    end
    if (!DIP_LOAD_n) load_cnt++;
    if (!p_load && DIP_LOAD_n) load_w = load_cnt;
    if (!p_sck && DIP_SCK) n_sck++;
    if (!p_valid && cfg_valid) t_valid = ncnt;
    p_load = DIP_LOAD_n; p_sck = DIP_SCK; p_valid = cfg_valid;
  end

  logic [7:0] m_raw = 8'd0, m_shadow = 8'd0;
  logic       m_ov = 1'b0, m_valid = 1'b0;

  function automatic logic [7:0] cfg_exp();
    return m_ov ? m_shadow : m_raw;
  endfunction

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic rs, input logic rd, input logic [7:0] d,
                     output logic [7:0] q, output int lat, output int t_ack);
    @(negedge CLK);
    sel = 1'b1; reg_sel = rs; READ = rd; DIN = d; FCS_n = 1'b0;
    lat = 0;
    do begin @(negedge CLK); lat++; end while (!dtack && lat < 500);
    chk("dtack_rise", dtack, 1'b1);
    q = DOUT; t_ack = ncnt;
    FCS_n = 1'b1; sel = 1'b0;
    @(negedge CLK); chk("dtack_hold", dtack, 1'b1);
    @(negedge CLK); chk("dtack_fall", dtack, 1'b0);
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_cfg"}, cfg, cfg_exp());
    chk({tag, "_ext_term"}, ext_term, cfg_exp() & 8'h01);
    chk({tag, "_valid"}, cfg_valid, m_valid);
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_dout"}, DOUT, 8'hFF);
    chk({tag, "_dtack"}, dtack, 1'b0);
    chk({tag, "_load_n"}, DIP_LOAD_n, 1'b1);
    chk({tag, "_sck"}, DIP_SCK, 1'b0);
    chk({tag, "_cfg"}, cfg, 8'h00);
    chk({tag, "_valid"}, cfg_valid, 1'b0);
    chk({tag, "_ext_term"}, ext_term, 1'b0);
  endtask

  // Starts a rescan from idle and waits for it through a stalled config read.
  task automatic do_rescan(input logic [7:0] lines, input logic [7:0] ctl);
    logic [7:0] q;
    int lat, ta_w, ta_r;
    sw_lines = lines;
    bus(1'b1, 1'b0, ctl, q, lat, ta_w);
    chk("ctl_wr_lat", lat, 2);
    if (ctl[1]) m_ov = 1'b0;
    chk("rescan_load_delay", t_load - ta_w, 2);
    bus(1'b0, 1'b1, 8'h00, q, lat, ta_r);
    m_raw = ~lines; m_valid = 1'b1;
    chk("scan_len", ta_r - t_load, c_scan_len + 1);
    chk("scan_read", q, cfg_exp());
    chk("load_width", load_w, c_clk_div);
    chk("sck_pulses", n_sck - sck_base, 8);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] q, ctl;
    logic [31:0] rnd;
    int lat, ta, n_rel, k, loads_before;

    sw_lines = 8'b1010_0110;
    sr = sw_lines;
    #2 RESET_n = 1'b0;
    #1 check_reset_outs("por");
    repeat (2) @(negedge CLK);
    RESET_n = 1'b1;
    n_rel = ncnt;

    bus(1'b1, 1'b1, 8'h00, q, lat, ta);
    chk("status_first_scan", q, 8'h80);
    chk("status_lat", lat, 2);
    while (ncnt < n_rel + 10) @(negedge CLK);
    bus(1'b0, 1'b1, 8'h00, q, lat, ta);
    m_raw = ~sw_lines; m_valid = 1'b1;
    chk("load_after_reset", t_load, n_rel + 1);
    chk("first_scan_len", t_valid - t_load, c_scan_len);
    chk("stalled_dtack", ta - t_valid, 1);
    chk("first_read", q, 8'h59);
    chk("first_cfg", cfg, 8'h59);
    chk("first_ext_term", ext_term, 1'b1);
    check_outs("after_first");

    bus(1'b0, 1'b0, 8'h3C, q, lat, ta);
    m_shadow = 8'h3C; m_ov = 1'b1;
    chk("cfg_wr_lat", lat, 2);
    chk("override_cfg", cfg, 8'h3C);
    sw_lines = 8'h5A;
    bus(1'b1, 1'b0, 8'h01, q, lat, ta);
    chk("rescan_load_delay2", t_load - ta, 2);
    bus(1'b1, 1'b1, 8'h00, q, lat, ta);
    chk("status_busy", q, 8'hE0);
    loads_before = n_loads;
    bus(1'b1, 1'b0, 8'h01, q, lat, ta);
    bus(1'b0, 1'b1, 8'h00, q, lat, ta);
    m_raw = 8'hA5;
    chk("busy_rescan_ignored", n_loads, loads_before);
    chk("busy_scan_len", ta - t_load, c_scan_len + 1);
    chk("override_read", q, 8'h3C);
    bus(1'b1, 1'b1, 8'h00, q, lat, ta);
    chk("status_idle", q, 8'h60);
    check_outs("override_kept");

    bus(1'b1, 1'b0, 8'h02, q, lat, ta);
    m_ov = 1'b0;
    chk("override_clear_cfg", cfg, 8'hA5);
    check_outs("override_clear");

    sw_lines = 8'h0F;
    bus(1'b1, 1'b0, 8'h01, q, lat, ta);
    k = 0;
    do begin @(negedge CLK); k++; end while (!DIP_SCK && k < 200);
    chk("sck_seen", DIP_SCK, 1'b1);
    #2 RESET_n = 1'b0;
    #1 check_reset_outs("mid_reset");
    m_raw = 8'h00; m_shadow = 8'h00; m_ov = 1'b0; m_valid = 1'b0;
    @(negedge CLK);
    RESET_n = 1'b1;
    n_rel = ncnt;
    k = 0;
    do begin @(negedge CLK); k++; end while (!cfg_valid && k < 500);
    chk("rescan_after_reset", cfg_valid, 1'b1);
    m_raw = ~sw_lines; m_valid = 1'b1;
    chk("reset_load", t_load, n_rel + 1);
    chk("reset_scan_len", t_valid - t_load, c_scan_len);
    chk("reset_cfg", cfg, 8'hF0);
    check_outs("after_mid_reset");

    for (int i = 0; i < 40; i++) begin
      rnd = $urandom;
      ctl = rnd[15:8];
      case (rnd[18:16] % 5)
        0: begin
          ctl[0] = 1'b1;
          do_rescan(rnd[7:0], ctl);
        end
        1: begin
          bus(1'b0, 1'b0, rnd[7:0], q, lat, ta);
          m_shadow = rnd[7:0]; m_ov = 1'b1;
          chk("rnd_cfg_wr_lat", lat, 2);
        end
        2: begin
          ctl[0] = 1'b0;
          bus(1'b1, 1'b0, ctl, q, lat, ta);
          if (ctl[1]) m_ov = 1'b0;
          chk("rnd_ctl_wr_lat", lat, 2);
        end
        3: begin
          bus(1'b1, 1'b1, 8'h00, q, lat, ta);
          chk("rnd_status", q, {1'b0, m_ov, m_valid, 5'b0});
          chk("rnd_status_lat", lat, 2);
        end
        default: begin
          bus(1'b0, 1'b1, 8'h00, q, lat, ta);
          chk("rnd_cfg_read", q, cfg_exp());
          chk("rnd_cfg_read_lat", lat, 2);
        end
      endcase
      check_outs("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
